// File: rtl/watch_ctrl.sv
// Digital watch controller: HH:MM:SS timekeeping with a mode-driven field-set sequence.
// Optional alarm (extra set states, dismiss flag, alarm output) is enabled by defining WATCH_ALARM_EN.
module watch_ctrl #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [2:0] mode,
  output logic       blink,
  output logic       tick_min,
  output logic       alarm
);

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_HOUR    = 3'd1,
    SET_MIN     = 3'd2,
    SET_SEC     = 3'd3,
    SET_AL_HOUR = 3'd4,
    SET_AL_MIN  = 3'd5
  } state_e;

  localparam logic [4:0] HourMaxC = 5'(HOUR_MAX);

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       blink_q, blink_d;
  logic       tick_min_q, tick_min_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      blink_q    <= 1'b0;
      tick_min_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      blink_q    <= blink_d;
      tick_min_q <= tick_min_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    blink_d    = blink_q;
    tick_min_d = 1'b0;

    // The seconds tick in RUN is applied even when btn_mode leaves RUN on the same edge.
    if (state_q == RUN && en_1hz) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d      = 6'd0;
          tick_min_d = 1'b1;
          hour_d     = (hour_q == HourMaxC) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (btn_mode) begin
      blink_d = 1'b0;
      case (state_q)
        RUN:         state_d = SET_HOUR;
        SET_HOUR:    state_d = SET_MIN;
        SET_MIN:     state_d = SET_SEC;
`ifdef WATCH_ALARM_EN
        SET_SEC:     state_d = SET_AL_HOUR;
        SET_AL_HOUR: state_d = SET_AL_MIN;
`endif
        default:     state_d = RUN;
      endcase
    end else begin
      if (state_q == RUN) begin
        blink_d = 1'b0;
      end else if (en_1hz) begin
        blink_d = ~blink_q;
      end
      if (btn_inc) begin
        case (state_q)
          SET_HOUR: hour_d = (hour_q == HourMaxC) ? 5'd0 : hour_q + 5'd1;
          SET_MIN:  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          SET_SEC:  sec_d  = 6'd0;
          default:  ;
        endcase
      end
    end
  end

`ifdef WATCH_ALARM_EN
  logic [4:0] al_hour_q, al_hour_d;
  logic [5:0] al_min_q, al_min_d;
  logic       dismiss_q, dismiss_d;
  logic       alarm_q, alarm_d;
  logic       match_d;

  // Dismiss starts set so that the power-on 00:00 match with a cleared alarm time stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      al_hour_q <= 5'd0;
      al_min_q  <= 6'd0;
      dismiss_q <= 1'b1;
      alarm_q   <= 1'b0;
    end else begin
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      dismiss_q <= dismiss_d;
      alarm_q   <= alarm_d;
    end
  end

  // Match is evaluated on next-state values so alarm rises on the same edge the time reaches it.
  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    if (btn_inc && !btn_mode) begin
      if (state_q == SET_AL_HOUR) begin
        al_hour_d = (al_hour_q == HourMaxC) ? 5'd0 : al_hour_q + 5'd1;
      end
      if (state_q == SET_AL_MIN) begin
        al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
      end
    end
    match_d   = (hour_d == al_hour_d) && (min_d == al_min_d);
    dismiss_d = dismiss_q;
    if (!match_d) begin
      dismiss_d = 1'b0;
    end else if (state_q == RUN && btn_inc && !btn_mode) begin
      dismiss_d = 1'b1;
    end
    alarm_d = (state_d == RUN) && match_d && !dismiss_d;
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign mode     = state_q;
  assign blink    = blink_q;
  assign tick_min = tick_min_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// Self-checking bench for watch_ctrl: a time-of-day-in-seconds model checked every cycle,
// plus directed scenarios with literal expectations. Alarm scenario runs when WATCH_ALARM_EN is defined.
module tb_watch_ctrl;

  localparam int HM  = 23;
  localparam int DAY = (HM + 1) * 3600;
`ifdef WATCH_ALARM_EN
  localparam int NST = 6;
`else
  localparam int NST = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] mode;
  logic       blink;
  logic       tick_min;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  watch_ctrl #(.HOUR_MAX(HM)) dut (
    .clk(clk), .rst(rst), .en_1hz(en_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .mode(mode), .blink(blink),
    .tick_min(tick_min), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Model state: whole time of day as one seconds count, mode as an index into the set sequence.
  int tod = 0, idx = 0, mBlink = 0, mTick = 0, mAlarm = 0;
  int mAh = 0, mAm = 0, mDis = 1;
  int h, m, s, incRun, match;
  bit armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      tod = 0; idx = 0; mBlink = 0; mTick = 0; mAlarm = 0;
      mAh = 0; mAm = 0; mDis = 1;
      armed = 1'b1;
    end else begin
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
      mTick = 0; incRun = 0;
      if (idx == 0 && en_1hz) begin
        tod = (tod + 1) % DAY;
        if (tod % 3600 == 0) mTick = 1;
      end
      if (btn_mode) begin
        idx = (idx + 1) % NST;
        mBlink = 0;
      end else begin
        if (idx != 0 && en_1hz) mBlink = 1 - mBlink;
        if (btn_inc) begin
          case (idx)
            0: incRun = 1;
            1: tod = ((h + 1) % (HM + 1)) * 3600 + m * 60 + s;
            2: tod = h * 3600 + ((m + 1) % 60) * 60 + s;
            3: tod = h * 3600 + m * 60;
            4: mAh = (mAh + 1) % (HM + 1);
            5: mAm = (mAm + 1) % 60;
            default: ;
          endcase
        end
      end
`ifdef WATCH_ALARM_EN
      match = (tod / 3600 == mAh) && ((tod / 60) % 60 == mAm);
      if (!match) mDis = 0;
      else if (incRun != 0) mDis = 1;
      mAlarm = (idx == 0 && match != 0 && mDis == 0) ? 1 : 0;
`else
      mAlarm = 0;
`endif
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("model_sec", int'(sec), tod % 60);
      checkOutput("model_min", int'(min), (tod / 60) % 60);
      checkOutput("model_hour", int'(hour), tod / 3600);
      checkOutput("model_mode", int'(mode), idx);
      checkOutput("model_blink", int'(blink), mBlink);
      checkOutput("model_tick_min", int'(tick_min), mTick);
      checkOutput("model_alarm", int'(alarm), mAlarm);
    end
  end

  // Called at a falling edge: drive for one rising edge, return at the next falling edge.
  task automatic applyStimulus(input bit r, input bit md, input bit inc, input bit t);
    rst = r; btn_mode = md; btn_inc = inc; en_1hz = t;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; en_1hz = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_sec", int'(sec), 0);
    checkOutput("reset_min", int'(min), 0);
    checkOutput("reset_hour", int'(hour), 0);
    checkOutput("reset_mode", int'(mode), 0);
    checkOutput("reset_blink", int'(blink), 0);
    checkOutput("reset_alarm", int'(alarm), 0);

    applyStimulus(0, 1, 0, 0);
    checkOutput("enter_set_hour", int'(mode), 1);
    for (int k = 0; k < 25; k++) applyStimulus(0, 0, 1, (k % 5) == 0);
    checkOutput("hour_after_25_inc", int'(hour), 1);
    checkOutput("sec_frozen", int'(sec), 0);
    checkOutput("blink_after_5_ticks", int'(blink), 1);

    applyStimulus(0, 1, 1, 0);
    checkOutput("mode_inc_mode", int'(mode), 2);
    checkOutput("mode_inc_hour", int'(hour), 1);
    checkOutput("mode_inc_blink", int'(blink), 0);

    for (int k = 0; k < 37; k++) applyStimulus(0, 0, 1, 0);
    checkOutput("min_set_37", int'(min), 37);
    applyStimulus(1, 1, 0, 1);
    checkOutput("rst_in_set_mode", int'(mode), 0);
    checkOutput("rst_in_set_min", int'(min), 0);
    checkOutput("rst_in_set_hour", int'(hour), 0);

    // Preload 23:59:00 through the set states, then tick up to :58 in RUN.
    applyStimulus(0, 1, 0, 0);
    for (int k = 0; k < 23; k++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int k = 0; k < NST - 3; k++) applyStimulus(0, 1, 0, 0);
    checkOutput("back_in_run", int'(mode), 0);
    for (int k = 0; k < 58; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("preload_hour", int'(hour), 23);
    checkOutput("preload_min", int'(min), 59);
    checkOutput("preload_sec", int'(sec), 58);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t59_sec", int'(sec), 59);
    checkOutput("t59_tick_min", int'(tick_min), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_hour", int'(hour), 0);
    checkOutput("wrap_min", int'(min), 0);
    checkOutput("wrap_sec", int'(sec), 0);
    checkOutput("wrap_tick_min", int'(tick_min), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tick_min_one_cycle", int'(tick_min), 0);

    applyStimulus(0, 1, 0, 1);
    checkOutput("tick_and_mode_sec", int'(sec), 1);
    checkOutput("tick_and_mode_mode", int'(mode), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("set_tick_sec", int'(sec), 1);
    checkOutput("set_tick_blink", int'(blink), 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("state_change_blink", int'(blink), 0);
    for (int k = 0; k < 60; k++) applyStimulus(0, 0, 1, 0);
    checkOutput("min_wrap_no_carry_min", int'(min), 0);
    checkOutput("min_wrap_no_carry_hour", int'(hour), 0);
    for (int k = 0; k < NST - 2; k++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("resume_sec", int'(sec), 2);

`ifdef WATCH_ALARM_EN
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 0);
    checkOutput("al_set_mode", int'(mode), 5);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("al_before", int'(alarm), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("al_fire_min", int'(min), 1);
    checkOutput("al_fire", int'(alarm), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("al_dismissed", int'(alarm), 0);
    for (int k = 0; k < 60; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("al_at_0002_min", int'(min), 2);
    checkOutput("al_at_0002", int'(alarm), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_ctrl.md
WATCH_CTRL -- requirements
Module: watch_ctrl

Interface
REQ-001 Parameter: HOUR_MAX, default 23, highest hour value before wrap to 0; legal range 1..31.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en_1hz  input  1  one-cycle seconds tick from the 1 Hz enable generator.
REQ-005 btn_mode  input  1  one-cycle pulse (already debounced and edge-detected); advances the mode.
REQ-006 btn_inc  input  1  one-cycle pulse; increments the selected field, or dismisses the alarm in RUN.
REQ-007 sec  output  6  seconds, binary 0..59, registered.
REQ-008 min  output  6  minutes, binary 0..59, registered.
REQ-009 hour  output  5  hours, binary 0..HOUR_MAX, registered.
REQ-010 mode  output  3  current state encoding, registered.
REQ-011 blink  output  1  field-blink phase for the display, registered.
REQ-012 tick_min  output  1  one-cycle pulse on each minute rollover in RUN.
REQ-013 alarm  output  1  alarm active level, registered; held at 0 when WATCH_ALARM_EN is undefined.

Function
REQ-014 States SHALL be encoded as RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, SET_AL_HOUR=4, SET_AL_MIN=5.
REQ-015 btn_mode SHALL advance the state in the order RUN, SET_HOUR, SET_MIN, SET_SEC, then RUN, taking effect on the next edge.
REQ-016 In RUN, en_1hz SHALL increment sec; outputs update on the edge that samples en_1hz.
REQ-017 sec at 59 plus a tick SHALL become 0 and increment min; min at 59 with a sec wrap SHALL become 0 and increment hour; hour at HOUR_MAX with a min wrap SHALL become 0.
REQ-018 tick_min SHALL be high for exactly the cycle after a min wrap from 59 to 0 and low otherwise.
REQ-019 In any SET_* state, en_1hz SHALL NOT change sec, min or hour (time frozen).
REQ-020 In SET_HOUR, btn_inc SHALL increment hour, wrapping HOUR_MAX to 0 without carry.
REQ-021 In SET_MIN, btn_inc SHALL increment min, wrapping 59 to 0 without carry into hour.
REQ-022 In SET_SEC, btn_inc SHALL clear sec to 0.
REQ-023 blink SHALL be 0 in RUN and SHALL toggle on each en_1hz while in a SET_* state.
REQ-024 blink SHALL be forced to 0 on every state change.
REQ-025 Simultaneous btn_mode and btn_inc: btn_mode SHALL take effect and btn_inc SHALL be discarded.
REQ-026 Simultaneous en_1hz and btn_mode in RUN: the tick SHALL be applied and the state SHALL advance on the same edge.
REQ-027 On return to RUN, counting SHALL resume on the first subsequent en_1hz, with no partial-second compensation.

Reset
REQ-028 When rst is high at a clk edge: sec=0, min=0, hour=0, mode=RUN, blink=0, tick_min=0, alarm=0.
REQ-029 Also on reset: alarm hour/minute registers=0 and the dismiss flag=1.
REQ-030 rst SHALL take priority over all inputs, including mid-set-mode and coincident en_1hz.

Configuration
REQ-031 Macro WATCH_ALARM_EN: when defined, SET_SEC SHALL advance to SET_AL_HOUR, then SET_AL_MIN, then RUN.
REQ-032 With the macro, btn_inc SHALL increment the alarm hour in SET_AL_HOUR and the alarm minute in SET_AL_MIN, using the same wrap rules as REQ-020 and REQ-021.
REQ-033 With the macro, match is defined as hour==alarm hour AND min==alarm minute.
REQ-034 With the macro, alarm=1 while in RUN AND match AND dismiss flag=0; btn_inc in RUN SHALL set the dismiss flag.
REQ-035 With the macro, the dismiss flag SHALL clear on any cycle where match is false.
REQ-036 Without the macro: states 4 and 5 are unreachable, SET_SEC advances to RUN, no alarm registers exist, and alarm is tied to 0.

Verification
REQ-037 rst=1 for 2 clk with en_1hz=1 -> all outputs 0, mode=0, alarm=0 after release.
REQ-038 Preload 23:59:58, RUN, 2 ticks -> 23:59:59, then 00:00:00; tick_min high exactly 1 cycle.
REQ-039 btn_mode x1, then btn_inc x25 with HOUR_MAX=23 -> hour cycles to 1; en_1hz ticks leave sec unchanged; blink toggles per tick.
REQ-040 btn_mode and btn_inc in the same cycle in SET_HOUR -> mode=SET_MIN, hour unchanged.
REQ-041 WATCH_ALARM_EN defined, alarm set to 00:01, run from 00:00:59 -> alarm=1 at 00:01:00; btn_inc -> alarm=0; remains 0 through 00:02, then rearmed.
REQ-042 Reset asserted in SET_MIN with min=37 -> mode=RUN, min=0 on the next edge.
